// File: rtl/dec_pkg.sv
// Shared decoder constants: 4-PAM constellation points and default distance word format.
// Used by dx_min_sel and dx_cal so both agree on the index-to-point mapping.
package dec_pkg;

  localparam int DEC_N  = 16;
  localparam int DEC_Q  = 8;
  localparam int PT_NUM = 4;
  localparam int PT_VAL [PT_NUM] = '{-3, -1, 1, 3};

  function automatic int point_of(input logic [1:0] idx);
    return PT_VAL[idx];
  endfunction

endpackage

// File: rtl/dx_min2.sv
// Combinational two-way compare-select on squared distances.
// Negative words (multiplier wrap) are forced to the largest positive value; 'a' wins ties.
module dx_min2
  import dec_pkg::*;
#(
  parameter int N = DEC_N
) (
  input  logic [N-1:0] a,
  input  logic [1:0]   a_idx,
  input  logic [N-1:0] b,
  input  logic [1:0]   b_idx,
  output logic [N-1:0] min_val,
  output logic [1:0]   min_idx
);

  localparam logic [N-1:0] POS_MAX = {1'b0, {(N-1){1'b1}}};

  logic [N-1:0] a_san_s;
  logic [N-1:0] b_san_s;

  // Sanitise both operands, then keep the strictly smaller one
  always_comb begin
    a_san_s = a[N-1] ? POS_MAX : a;
    b_san_s = b[N-1] ? POS_MAX : b;
    if (b_san_s < a_san_s) begin
      min_val = b_san_s;
      min_idx = b_idx;
    end else begin
      min_val = a_san_s;
      min_idx = a_idx;
    end
  end

endmodule

// File: rtl/dx_min_sel.sv
// Two-stage minimum-distance symbol selector with per-frame saturating metric sum.
// S1 holds the pairwise minima, S2 holds the decision presented to the consumer.
module dx_min_sel
  import dec_pkg::*;
#(
  parameter int N         = DEC_N,
  parameter int Q         = DEC_Q,
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = N + 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] d0,
  input  logic signed [N-1:0] d1,
  input  logic signed [N-1:0] d2,
  input  logic signed [N-1:0] d3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          sym_idx,
  output logic [N-1:0]        sym_val,
  output logic [N-1:0]        sym_metric,
  output logic                frame_done,
  output logic [ACC_W-1:0]    frame_metric
);

  localparam int               CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

  logic             s1_full_r;
  logic             s2_full_r;
  logic [N-1:0]     s1_val01_r, s1_val23_r;
  logic [1:0]       s1_idx01_r, s1_idx23_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ACC_W-1:0] acc_r;

  logic             s2_advance_s;
  logic             in_fire_s;
  logic [N-1:0]     m01_val_s, m23_val_s, fin_val_s;
  logic [1:0]       m01_idx_s, m23_idx_s, fin_idx_s;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] fm_next_s;
  logic             fd_next_s;
  logic [N-1:0]     val_next_s;

  assign s2_advance_s = !s2_full_r || out_ready;
  assign in_ready     = !s1_full_r || s2_advance_s;
  assign in_fire_s    = in_valid && in_ready;
  assign out_valid    = s2_full_r;

  dx_min2 #(.N(N)) u_min01 (
    .a(d0), .a_idx(2'd0), .b(d1), .b_idx(2'd1),
    .min_val(m01_val_s), .min_idx(m01_idx_s)
  );

  dx_min2 #(.N(N)) u_min23 (
    .a(d2), .a_idx(2'd2), .b(d3), .b_idx(2'd3),
    .min_val(m23_val_s), .min_idx(m23_idx_s)
  );

  // Lower pair goes on 'a' so an exact tie across pairs keeps the lower index
  dx_min2 #(.N(N)) u_min_fin (
    .a(s1_val01_r), .a_idx(s1_idx01_r), .b(s1_val23_r), .b_idx(s1_idx23_r),
    .min_val(fin_val_s), .min_idx(fin_idx_s)
  );

  // Decision fields and frame bookkeeping for the symbol about to enter S2
  always_comb begin
    sum_s      = {1'b0, acc_r} + (ACC_W+1)'(fin_val_s);
    fm_next_s  = sum_s[ACC_W] ? ACC_MAX : sum_s[ACC_W-1:0];
    fd_next_s  = (cnt_r == CNT_LAST);
    val_next_s = N'(point_of(fin_idx_s) <<< Q);
  end

  // Stage 1: capture the pairwise minima on an input transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full_r  <= 1'b0;
      s1_val01_r <= {N{1'b0}};
      s1_val23_r <= {N{1'b0}};
      s1_idx01_r <= 2'd0;
      s1_idx23_r <= 2'd0;
    end else if (in_fire_s) begin
      s1_full_r  <= 1'b1;
      s1_val01_r <= m01_val_s;
      s1_val23_r <= m23_val_s;
      s1_idx01_r <= m01_idx_s;
      s1_idx23_r <= m23_idx_s;
    end else if (s2_advance_s) begin
      s1_full_r  <= 1'b0;
    end else begin
      s1_full_r  <= s1_full_r;
    end
  end

  // Stage 2: final decision, frame position and running metric
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_full_r    <= 1'b0;
      sym_idx      <= 2'd0;
      sym_val      <= {N{1'b0}};
      sym_metric   <= {N{1'b0}};
      frame_done   <= 1'b0;
      frame_metric <= {ACC_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      acc_r        <= {ACC_W{1'b0}};
    end else if (s2_advance_s) begin
      s2_full_r <= s1_full_r;
      if (s1_full_r) begin
        sym_idx      <= fin_idx_s;
        sym_val      <= val_next_s;
        sym_metric   <= fin_val_s;
        frame_done   <= fd_next_s;
        frame_metric <= fm_next_s;
        // The frame-closing symbol can only leave S2 before the next one loads,
        // so clearing here starts the following frame from zero
        cnt_r        <= fd_next_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        acc_r        <= fd_next_s ? {ACC_W{1'b0}} : fm_next_s;
      end else begin
        frame_done   <= 1'b0;
      end
    end else begin
      s2_full_r <= s2_full_r;
    end
  end

endmodule

// File: tb/tb_dx_min_sel.sv
// Self-checking bench for dx_min_sel: directed vectors, frame/backpressure/reset
// sequences and a random stream scored against a queue-based reference model.
module tb_dx_min_sel;

  localparam int N      = 16;
  localparam int Q      = 8;
  localparam int FL     = 4;
  localparam int ACC_W  = 24;
  localparam int ACC_WB = 16;
  localparam longint ACC_MAX  = (64'd1 << ACC_W) - 1;
  localparam longint ACC_MAXB = (64'd1 << ACC_WB) - 1;

  logic              clk, rst, in_valid, out_ready;
  logic [N-1:0]      d0, d1, d2, d3;
  logic              in_ready, out_valid, frame_done;
  logic [1:0]        sym_idx;
  logic [N-1:0]      sym_val, sym_metric;
  logic [ACC_W-1:0]  frame_metric;
  logic              in_ready_b, out_valid_b, frame_done_b;
  logic [1:0]        sym_idx_b;
  logic [N-1:0]      sym_val_b, sym_metric_b;
  logic [ACC_WB-1:0] frame_metric_b;

  dx_min_sel #(.N(N), .Q(Q), .FRAME_LEN(FL), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_valid(out_valid), .out_ready(out_ready),
    .sym_idx(sym_idx), .sym_val(sym_val), .sym_metric(sym_metric),
    .frame_done(frame_done), .frame_metric(frame_metric)
  );

  dx_min_sel #(.N(N), .Q(Q), .FRAME_LEN(FL), .ACC_W(ACC_WB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .sym_idx(sym_idx_b), .sym_val(sym_val_b), .sym_metric(sym_metric_b),
    .frame_done(frame_done_b), .frame_metric(frame_metric_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] val;
    logic [15:0] metric;
  } exp_t;

  typedef struct packed {
    logic        fd;
    logic [23:0] fm;
    logic [15:0] fm_b;
  } obs_t;

  typedef struct packed {
    logic [15:0] a, b, c, e;
    logic [1:0]  idx;
    logic [15:0] val, metric;
  } vec_t;

  exp_t   exp_q[$];
  obs_t   obs_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     out_pos  = 0;
  longint acc      = 0;
  longint acc_b    = 0;
  int     n_in     = 0;
  int     n_out    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Reference: sanitise negatives, pick the smallest, lowest index wins a tie
  function automatic exp_t model(input logic [15:0] a, b, c, e);
    logic [15:0] dv[4];
    longint      m[4];
    int          best;
    exp_t        r;
    dv = '{a, b, c, e};
    for (int i = 0; i < 4; i++) m[i] = ($signed(dv[i]) < 0) ? 32767 : longint'(dv[i]);
    best = 0;
    for (int i = 1; i < 4; i++) if (m[i] < m[best]) best = i;
    r.idx    = 2'(best);
    r.val    = 16'(((best * 2) - 3) * 256);
    r.metric = 16'(m[best]);
    return r;
  endfunction

  task automatic set_d(input logic [15:0] a, b, c, e);
    d0 = a; d1 = b; d2 = c; d3 = e;
  endtask

  // One clock: score outputs and transfers just before the edge, then step past it
  task automatic cycle();
    exp_t   e;
    logic   fd_exp;
    longint s, fm_exp, fm_exp_b;
    @(negedge clk);
    chk("inst_b_in_ready", in_ready_b, in_ready);
    chk("inst_b_out_valid", out_valid_b, out_valid);
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 1'b1, 1'b0);
      end else begin
        e        = exp_q[0];
        fd_exp   = (out_pos == FL - 1);
        s        = acc + longint'(e.metric);
        fm_exp   = (s > ACC_MAX) ? ACC_MAX : s;
        s        = acc_b + longint'(e.metric);
        fm_exp_b = (s > ACC_MAXB) ? ACC_MAXB : s;
        chk("sym_idx", sym_idx, e.idx);
        chk("sym_val", sym_val, e.val);
        chk("sym_metric", sym_metric, e.metric);
        chk("frame_done", frame_done, fd_exp);
        chk("inst_b_sym_metric", sym_metric_b, e.metric);
        if (fd_exp) begin
          chk("frame_metric", frame_metric, fm_exp);
          chk("inst_b_frame_metric", frame_metric_b, fm_exp_b);
        end
        if (out_ready && !rst) begin
          void'(exp_q.pop_front());
          obs_q.push_back('{fd: frame_done, fm: frame_metric, fm_b: frame_metric_b});
          acc     = fd_exp ? 0 : fm_exp;
          acc_b   = fd_exp ? 0 : fm_exp_b;
          out_pos = (out_pos + 1) % FL;
          n_out++;
        end
      end
    end
    if (rst) begin
      exp_q.delete();
      acc = 0; acc_b = 0; out_pos = 0;
    end else if (in_valid && in_ready) begin
      exp_q.push_back(model(d0, d1, d2, d3));
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) cycle();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  vec_t   tbl[8];
  logic [15:0] fr_m[8];
  exp_t   e0;
  int     n_in0, n_out0;
  logic [15:0] ra, rb, rc, re;

  function automatic logic [15:0] rnd_d();
    case ($urandom % 8)
      0:       return 16'h8000 | 16'($urandom);
      1, 2:    return 16'($urandom_range(0, 7) << 8);
      default: return 16'($urandom_range(0, 32767));
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_d(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_sym_idx", sym_idx, 2'd0);
    chk("rst_sym_val", sym_val, 16'h0000);
    chk("rst_sym_metric", sym_metric, 16'h0000);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_frame_metric", frame_metric, 24'h000000);

    // Directed vectors: each checked exactly two edges after acceptance
    tbl[0] = '{16'h0900, 16'h0100, 16'h0100, 16'h0900, 2'd1, 16'hFF00, 16'h0100};
    tbl[1] = '{16'h8000, 16'h7000, 16'h0400, 16'h0200, 2'd3, 16'h0300, 16'h0200};
    tbl[2] = '{16'h0500, 16'h0500, 16'h0500, 16'h0500, 2'd0, 16'hFD00, 16'h0500};
    tbl[3] = '{16'h8000, 16'hFFFF, 16'h9000, 16'hC000, 2'd0, 16'hFD00, 16'h7FFF};
    tbl[4] = '{16'h0300, 16'h0200, 16'h0001, 16'h0002, 2'd2, 16'h0100, 16'h0001};
    tbl[5] = '{16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 2'd0, 16'hFD00, 16'h0000};
    tbl[6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFE, 2'd3, 16'h0300, 16'h7FFE};
    tbl[7] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 2'd0, 16'hFD00, 16'h7FFF};
    for (int i = 0; i < 8; i++) begin
      set_d(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].e);
      in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      chk("vec_latency_valid", out_valid, 1'b1);
      chk("vec_sym_idx", sym_idx, tbl[i].idx);
      chk("vec_sym_val", sym_val, tbl[i].val);
      chk("vec_sym_metric", sym_metric, tbl[i].metric);
    end
    drain();

    // Two frames back to back; second sum must not include the first
    do_reset();
    obs_q.delete();
    fr_m = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
    for (int k = 0; k < 8; k++) begin
      set_d(fr_m[k], 16'h7FFF, 16'h7FFF, 16'h7FFF);
      in_valid = 1'b1;
      cycle();
    end
    drain();
    chk("frame_obs_count", obs_q.size(), 8);
    if (obs_q.size() == 8) begin
      for (int k = 0; k < 8; k++) chk("frame_done_pos", obs_q[k].fd, (k == 3 || k == 7));
      chk("frame1_metric", obs_q[3].fm, 24'h0000A0);
      chk("frame2_metric", obs_q[7].fm, 24'h00001A);
    end

    // Saturation at 2^ACC_W-1 on the narrow-accumulator instance
    do_reset();
    obs_q.delete();
    for (int k = 0; k < 4; k++) begin
      set_d(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      in_valid = 1'b1;
      cycle();
    end
    drain();
    chk("sat_obs_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("sat_frame_done", obs_q[3].fd, 1'b1);
      chk("sat_metric_narrow", obs_q[3].fm_b, 16'hFFFF);
      chk("sat_metric_wide", obs_q[3].fm, 24'h01FFFC);
    end

    // Backpressure from an empty pipeline: only two symbols fit
    do_reset();
    out_ready = 1'b0;
    n_in0 = n_in; n_out0 = n_out;
    for (int k = 0; k < 5; k++) begin
      ra = 16'($urandom_range(0, 32767)); rb = 16'($urandom_range(0, 32767));
      rc = 16'($urandom_range(0, 32767)); re = 16'($urandom_range(0, 32767));
      if (k == 0) e0 = model(ra, rb, rc, re);
      set_d(ra, rb, rc, re);
      in_valid = 1'b1;
      cycle();
    end
    chk("bp_accepted", n_in - n_in0, 2);
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_hold_valid", out_valid, 1'b1);
    chk("bp_hold_idx", sym_idx, e0.idx);
    chk("bp_hold_val", sym_val, e0.val);
    chk("bp_hold_metric", sym_metric, e0.metric);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_d(rnd_d(), rnd_d(), rnd_d(), rnd_d());
      cycle();
    end
    drain();
    chk("bp_no_loss", n_out - n_out0, n_in - n_in0);

    // Reset with two symbols in flight discards the partial frame
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_d(16'h0100, 16'h0200, 16'h0300, 16'h0400);
      in_valid = 1'b1;
      cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    obs_q.delete();
    for (int k = 0; k < 4; k++) begin
      set_d(16'h0050, 16'h0060, 16'h0070, 16'h0080);
      in_valid = 1'b1;
      cycle();
    end
    drain();
    chk("midrst_obs_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("midrst_frame_done", obs_q[k].fd, (k == 3));
      chk("midrst_frame_metric", obs_q[3].fm, 24'h000140);
    end

    // Random traffic with random backpressure
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      set_d(rnd_d(), rnd_d(), rnd_d(), rnd_d());
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dx_min_sel.md
DX_MIN_SEL -- requirements
Module: dx_min_sel

Interface
REQ-001 SHALL have parameter N, default 16, total fixed-point width of each distance word.
REQ-002 SHALL have parameter Q, default 8, fractional bits of each distance word.
REQ-003 SHALL have parameter FRAME_LEN, default 4, symbols per decoding frame (power of two, 2..256).
REQ-004 SHALL have parameter ACC_W, default N+8, frame-metric accumulator width.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports as follows (name direction width meaning):
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  d0..d3 valid
- in_ready  output  1  block accepts d0..d3
- d0, d1, d2, d3  input  N each  signed Q-format squared distances to points -3, -1, +1, +3
- out_valid  output  1  decision valid
- out_ready  input  1  consumer accepts decision
- sym_idx  output  2  winning point index 0..3
- sym_val  output  N  signed Q-format winning point value (idx<<1)-3, shifted left by Q
- sym_metric  output  N  winning distance, after sanitising
- frame_done  output  1  this decision is the last of a frame
- frame_metric  output  ACC_W  sum of sym_metric over the frame; valid only while frame_done=1

Function
REQ-007 SHALL complete an input transfer on in_valid&&in_ready and an output transfer on out_valid&&out_ready.
REQ-008 SHALL use a two-stage pipeline:
- S1 registers pairwise minima (d0,d1) and (d2,d3).
- S2 registers the final minimum, index, value, and accumulator update.
REQ-009 SHALL have latency 2 cycles from input transfer to out_valid when there is no backpressure, and SHALL sustain 1 symbol per cycle.
REQ-010 SHALL drive in_ready = !S1_full || S2_advance, where S2_advance = !S2_full || out_ready (no combinational path from in_valid to in_ready).
REQ-011 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-012 SHALL sanitise any negative distance (qmult wrap) to the maximum positive N-bit value before comparison.
REQ-013 SHALL resolve ties by selecting the lowest index.
REQ-014 SHALL keep a frame counter that increments on each output transfer and wraps to 0 after FRAME_LEN-1.
REQ-015 SHALL assert frame_done together with out_valid when the counter equals FRAME_LEN-1.
REQ-016 SHALL compute frame_metric as the unsigned saturating sum at 2^ACC_W-1, including the current symbol.
REQ-017 SHALL clear the accumulator to 0 on the output transfer that carries frame_done, so the next frame starts at 0.
REQ-018 SHALL, on an output transfer and simultaneous S1 advance in the same cycle, load S2 with no bubble.

Reset
REQ-019 SHALL, on rst=1 at a clock edge, return to the following state regardless of any transfer in flight; that partial frame is discarded:
- S1_full=0, S2_full=0
- out_valid=0, in_ready=1 in the following cycle
- sym_idx=0, sym_val=0, sym_metric=0
- frame_done=0, frame_metric=0
- counter=0, accumulator=0
REQ-020 SHALL take no input transfer in a cycle where rst=1.

Structure
REQ-021 SHALL take constellation constants (-3,-1,1,3), default N and Q, and the index-to-value mapping from shared package dec_pkg, which dx_cal also uses.
REQ-022 SHALL implement the compare-select in sub-module dx_min2, which is combinational: sanitise, compare, and return the lower-index winner on ties. dx_min2 is instantiated three times.

Verification
REQ-023 SHALL verify with the following directed scenarios:
- Tie: d={0x0900,0x0100,0x0100,0x0900}, out_ready=1 -> 2 cycles later sym_idx=1, sym_val=0xFF00, sym_metric=0x0100.
- Negative sanitise: d={0x8000,0x7000,0x0400,0x0200} -> sym_idx=3, sym_val=0x0300, sym_metric=0x0200.
- Frame: 4 back-to-back symbols with metrics 0x0010,0x0020,0x0030,0x0040 -> frame_done only on the 4th, frame_metric=0x00A0. The 5th symbol starts a new frame with accumulator 0.
- Backpressure: out_ready=0 for 5 cycles during a stream -> in_ready falls after 2 accepted symbols, outputs stay constant, and no symbol is lost or duplicated after release.
- Saturation: ACC_W=N, FRAME_LEN=4, all metrics 0x7FFF -> frame_metric=0xFFFF.
- Reset mid-frame: rst=1 after 2 symbols accepted -> out_valid=0 next cycle, and the next 4 symbols form a full frame with frame_done on the 4th.
